// File: rtl/sort_test_harness.sv
// rtl/sort_test_harness.sv - SDRAM insertion-sorter self-test: LFSR fill, sort handoff, order and checksum check
module sort_test_harness #(
    parameter logic [31:0] TIMEOUT = 32'd50000000,
    parameter logic [5:0]  MAX_LEN = 6'd32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [5:0]  length,
    input  logic [15:0] seed,
    input  logic        waitrequest,
    input  logic        readdatavalid,
    input  logic [15:0] readdata,
    output logic        read_n,
    output logic        write_n,
    output logic        chipselect,
    output logic [31:0] address,
    output logic [1:0]  byteenable,
    output logic [15:0] writedata,
    output logic        bus_sel,
    output logic        sort_ready,
    input  logic        sort_done,
    output logic        busy,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [5:0]  err_count,
    output logic [31:0] sort_cycles
);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_SORT, S_RELEASE, S_CHECK, S_REPORT
    } state_t;

    state_t      state_q, state_d;
    logic        start_q, start_d;
    logic [5:0]  len_q, len_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [5:0]  idx_q, idx_d;
    logic [21:0] sum_in_q, sum_in_d;
    logic [21:0] sum_out_q, sum_out_d;
    logic [15:0] prev_q, prev_d;
    logic        rd_pend_q, rd_pend_d;
    logic [5:0]  err_count_q, err_count_d;
    logic [31:0] sort_cycles_q, sort_cycles_d;
    logic        pass_q, pass_d;
    logic        fail_q, fail_d;
    logic        timeout_q, timeout_d;
    logic        force_pass_q, force_pass_d;
    logic        force_fail_q, force_fail_d;

    logic        lfsr_fb;
    logic        verdict;
    logic [6:0]  chk_addr;

    assign lfsr_fb  = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    assign chk_addr = {1'b0, len_q} + {1'b0, idx_q};
    assign verdict  = (err_count_q == 6'd0) && (sum_in_q == sum_out_q) && !timeout_q;

    always_comb begin
        state_d       = state_q;
        start_d       = start;
        len_d         = len_q;
        lfsr_d        = lfsr_q;
        idx_d         = idx_q;
        sum_in_d      = sum_in_q;
        sum_out_d     = sum_out_q;
        prev_d        = prev_q;
        rd_pend_d     = rd_pend_q;
        err_count_d   = err_count_q;
        sort_cycles_d = sort_cycles_q;
        pass_d        = pass_q;
        fail_d        = fail_q;
        timeout_d     = timeout_q;
        force_pass_d  = force_pass_q;
        force_fail_d  = force_fail_q;
        read_n        = 1'b1;
        write_n       = 1'b1;
        address       = 32'd0;
        writedata     = 16'd0;
        bus_sel       = 1'b0;
        sort_ready    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !start_q) begin
                    len_d         = length;
                    lfsr_d        = (seed == 16'd0) ? 16'hACE1 : seed;
                    idx_d         = 6'd0;
                    rd_pend_d     = 1'b0;
                    sum_in_d      = 22'd0;
                    sum_out_d     = 22'd0;
                    err_count_d   = 6'd0;
                    sort_cycles_d = 32'd0;
                    pass_d        = 1'b0;
                    fail_d        = 1'b0;
                    timeout_d     = 1'b0;
                    force_pass_d  = 1'b0;
                    force_fail_d  = 1'b0;
                    if (length == 6'd0) begin
                        force_pass_d = 1'b1;
                        state_d      = S_REPORT;
                    end else if (length > MAX_LEN) begin
                        force_fail_d = 1'b1;
                        state_d      = S_REPORT;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                write_n   = 1'b0;
                address   = {26'd0, idx_q};
                writedata = lfsr_q;
                if (!waitrequest) begin
                    idx_d    = idx_q + 6'd1;
                    lfsr_d   = {lfsr_fb, lfsr_q[15:1]};
                    sum_in_d = sum_in_q + {6'd0, lfsr_q};
                    if (idx_q == len_q - 6'd1) begin
                        idx_d   = 6'd0;
                        state_d = S_SORT;
                    end
                end
            end
            S_SORT: begin
                bus_sel    = 1'b1;
                sort_ready = 1'b1;
                if (sort_cycles_q != 32'hFFFF_FFFF) begin
                    sort_cycles_d = sort_cycles_q + 32'd1;
                end
                if (sort_done) begin
                    state_d = S_RELEASE;
                end else if (sort_cycles_d >= TIMEOUT) begin
                    timeout_d = 1'b1;
                    state_d   = S_REPORT;
                end
            end
            S_RELEASE: begin
                // Keep the port with the sorter until it has dropped done and gone idle.
                bus_sel = 1'b1;
                if (!sort_done) begin
                    idx_d     = 6'd0;
                    rd_pend_d = 1'b0;
                    state_d   = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!rd_pend_q) begin
                    read_n  = 1'b0;
                    address = {25'd0, chk_addr};
                    if (!waitrequest) begin
                        rd_pend_d = 1'b1;
                    end
                end else if (readdatavalid) begin
                    rd_pend_d = 1'b0;
                    if ((idx_q != 6'd0) && (readdata < prev_q) && (err_count_q != 6'd63)) begin
                        err_count_d = err_count_q + 6'd1;
                    end
                    sum_out_d = sum_out_q + {6'd0, readdata};
                    prev_d    = readdata;
                    idx_d     = idx_q + 6'd1;
                    if (idx_q == len_q - 6'd1) begin
                        state_d = S_REPORT;
                    end
                end
            end
            S_REPORT: begin
                if (force_pass_q) begin
                    pass_d = 1'b1;
                    fail_d = 1'b0;
                end else if (force_fail_q) begin
                    pass_d = 1'b0;
                    fail_d = 1'b1;
                end else begin
                    pass_d = verdict;
                    fail_d = !verdict;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            start_q       <= 1'b0;
            len_q         <= 6'd0;
            lfsr_q        <= 16'd0;
            idx_q         <= 6'd0;
            sum_in_q      <= 22'd0;
            sum_out_q     <= 22'd0;
            prev_q        <= 16'd0;
            rd_pend_q     <= 1'b0;
            err_count_q   <= 6'd0;
            sort_cycles_q <= 32'd0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            timeout_q     <= 1'b0;
            force_pass_q  <= 1'b0;
            force_fail_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_q       <= start_d;
            len_q         <= len_d;
            lfsr_q        <= lfsr_d;
            idx_q         <= idx_d;
            sum_in_q      <= sum_in_d;
            sum_out_q     <= sum_out_d;
            prev_q        <= prev_d;
            rd_pend_q     <= rd_pend_d;
            err_count_q   <= err_count_d;
            sort_cycles_q <= sort_cycles_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
            timeout_q     <= timeout_d;
            force_pass_q  <= force_pass_d;
            force_fail_q  <= force_fail_d;
        end
    end

    assign chipselect  = 1'b1;
    assign byteenable  = 2'b11;
    assign busy        = (state_q != S_IDLE);
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;
    assign err_count   = err_count_q;
    assign sort_cycles = sort_cycles_q;

endmodule

// File: tb/tb_sort_test_harness.sv
// tb/tb_sort_test_harness.sv - directed bench: SDRAM slave and sorter models around sort_test_harness
module tb_sort_test_harness;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [5:0]  length;
    logic [15:0] seed;
    logic        waitrequest;
    logic        readdatavalid = 1'b0;
    logic [15:0] readdata = 16'd0;
    logic        read_n, write_n, chipselect;
    logic [31:0] address;
    logic [1:0]  byteenable;
    logic [15:0] writedata;
    logic        bus_sel, sort_ready;
    logic        sort_done = 1'b0;
    logic        busy, pass, fail, timeout;
    logic [5:0]  err_count;
    logic [31:0] sort_cycles;

    always #5 clk = ~clk;

    sort_test_harness #(.TIMEOUT(32'd100), .MAX_LEN(6'd32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .length(length), .seed(seed),
        .waitrequest(waitrequest), .readdatavalid(readdatavalid), .readdata(readdata),
        .read_n(read_n), .write_n(write_n), .chipselect(chipselect), .address(address),
        .byteenable(byteenable), .writedata(writedata), .bus_sel(bus_sel),
        .sort_ready(sort_ready), .sort_done(sort_done), .busy(busy), .pass(pass),
        .fail(fail), .timeout(timeout), .err_count(err_count), .sort_cycles(sort_cycles)
    );

    int n_pass = 0;
    int n_total = 0;

    // Slave and sorter model configuration, set by the stimulus sequence.
    int ws = 0;
    int lat = 1;
    int sort_mode = 0;
    int cur_len = 0;
    logic [15:0] img [0:63];
    logic [15:0] mem [0:127];

    int n_wr = 0, n_rd = 0, n_act = 0, stable_err = 0, own_err = 0;
    int stall_cnt = 0, rd_cnt = 0, sort_cnt = 0;
    logic [6:0]  rd_addr = 7'd0;
    logic        prev_stall = 1'b0, prev_wr = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    logic [15:0] prev_wd = 16'd0;
    logic        acc;

    assign acc         = !read_n || !write_n;
    assign waitrequest = acc && (stall_cnt < ws);

    always @(posedge clk) begin
        if (acc) n_act <= n_act + 1;
        if (bus_sel && acc) own_err <= own_err + 1;
        if (!reset_n) begin
            rd_cnt        <= 0;
            readdatavalid <= 1'b0;
            stall_cnt     <= 0;
            prev_stall    <= 1'b0;
            sort_cnt      <= 0;
            sort_done     <= 1'b0;
        end else begin
            readdatavalid <= 1'b0;
            if (rd_cnt != 0) begin
                rd_cnt <= rd_cnt - 1;
                if (rd_cnt == 1) begin
                    readdatavalid <= 1'b1;
                    readdata      <= mem[rd_addr];
                end
            end
            if (prev_stall && (!acc || address != prev_addr || (!write_n) != prev_wr
                               || (prev_wr && writedata != prev_wd)))
                stable_err <= stable_err + 1;
            prev_stall <= acc && waitrequest;
            prev_addr  <= address;
            prev_wd    <= writedata;
            prev_wr    <= !write_n;
            if (acc) begin
                if (waitrequest) begin
                    stall_cnt <= stall_cnt + 1;
                end else begin
                    stall_cnt <= 0;
                    if (!write_n) begin
                        mem[address[6:0]] <= writedata;
                        n_wr <= n_wr + 1;
                    end else begin
                        rd_cnt  <= lat;
                        rd_addr <= address[6:0];
                        n_rd    <= n_rd + 1;
                    end
                end
            end
            // Sorter: after a short delay dumps the prepared image and raises done.
            if (!sort_ready) begin
                sort_cnt  <= 0;
                sort_done <= 1'b0;
            end else if (!sort_done && sort_mode != 3) begin
                sort_cnt <= sort_cnt + 1;
                if (sort_cnt == 3) begin
                    for (int a = 0; a < 64; a++)
                        if (a < cur_len) mem[7'(cur_len + a)] <= img[a];
                    sort_done <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] lfsr_nx(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    // Build the sorter's output image; mode 1 swaps the last two, mode 2 bumps the last word.
    task automatic prep(input int len, input logic [15:0] sd, input int mode);
        logic [15:0] s, t;
        s = (sd == 16'd0) ? 16'hACE1 : sd;
        for (int a = 0; a < 64; a++) begin
            img[a] = (a < len) ? s : 16'hFFFF;
            if (a < len) s = lfsr_nx(s);
        end
        for (int a = 1; a < 64; a++)
            for (int b = a; b > 0; b--)
                if (b < len && img[b] < img[b-1]) begin
                    t = img[b]; img[b] = img[b-1]; img[b-1] = t;
                end
        if (mode == 1 && len >= 2) begin
            t = img[len-2]; img[len-2] = img[len-1]; img[len-1] = t;
        end
        if (mode == 2 && len >= 1) img[len-1] = img[len-1] + 16'd1;
        cur_len   = len;
        sort_mode = mode;
    endtask

    task automatic run_test(input string tag, input int len, input logic [15:0] sd,
                            input int mode, output int cyc);
        prep(len, sd, mode);
        length = len[5:0];
        seed   = sd;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (busy && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_complete"}, 32'(busy), 32'd0);
    endtask

    int cyc, w0, r0, a0, c;

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        length  = 6'd0;
        seed    = 16'd0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rw_n", {30'd0, read_n, write_n}, 32'd3);
        chk("rst_sel_ready", {30'd0, bus_sel, sort_ready}, 32'd0);
        chk("rst_flags", {29'd0, pass, fail, timeout}, 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        chk("rst_cycles", sort_cycles, 32'd0);
        chk("rst_addr", address, 32'd0);
        chk("rst_wdata", 32'(writedata), 32'd0);
        chk("const_cs_be", {29'd0, chipselect, byteenable}, 32'd7);

        // Basic zero-wait run, length 3.
        w0 = n_wr; r0 = n_rd;
        run_test("basic", 3, 16'hACE1, 0, cyc);
        chk("basic_mem0", 32'(mem[0]), 32'h0000ACE1);
        chk("basic_mem1", 32'(mem[1]), 32'h00005670);
        chk("basic_mem2", 32'(mem[2]), 32'h0000AB38);
        chk("basic_pass_fail", {30'd0, pass, fail}, 32'd2);
        chk("basic_err", 32'(err_count), 32'd0);
        chk("basic_cycles", sort_cycles, 32'd5);
        chk("basic_writes", 32'(n_wr - w0), 32'd3);
        chk("basic_reads", 32'(n_rd - r0), 32'd3);

        run_test("order", 3, 16'hACE1, 1, cyc);
        chk("order_err", 32'(err_count), 32'd1);
        chk("order_pass_fail", {30'd0, pass, fail}, 32'd1);

        run_test("sum", 3, 16'hACE1, 2, cyc);
        chk("sum_err", 32'(err_count), 32'd0);
        chk("sum_pass_fail", {30'd0, pass, fail}, 32'd1);

        // Stalling slave with slow read data.
        ws = 3; lat = 4; w0 = n_wr; r0 = n_rd;
        run_test("stall", 3, 16'hACE1, 0, cyc);
        chk("stall_pass_fail", {30'd0, pass, fail}, 32'd2);
        chk("stall_err", 32'(err_count), 32'd0);
        chk("stall_cycles", sort_cycles, 32'd5);
        chk("stall_writes", 32'(n_wr - w0), 32'd3);
        chk("stall_reads", 32'(n_rd - r0), 32'd3);
        chk("stall_stable", 32'(stable_err), 32'd0);
        ws = 0; lat = 1;

        a0 = n_act;
        run_test("len0", 0, 16'hACE1, 0, cyc);
        chk("len0_pass_fail", {30'd0, pass, fail}, 32'd2);
        chk("len0_latency_ok", 32'(cyc <= 2), 32'd1);
        chk("len0_bus_idle", 32'(n_act - a0), 32'd0);

        a0 = n_act;
        run_test("len40", 40, 16'hACE1, 0, cyc);
        chk("len40_pass_fail", {30'd0, pass, fail}, 32'd1);
        chk("len40_bus_idle", 32'(n_act - a0), 32'd0);

        w0 = n_wr;
        run_test("len32", 32, 16'h1D2C, 0, cyc);
        chk("len32_pass_fail", {30'd0, pass, fail}, 32'd2);
        chk("len32_writes", 32'(n_wr - w0), 32'd32);

        run_test("tmo", 3, 16'hACE1, 3, cyc);
        chk("tmo_flags", {29'd0, pass, fail, timeout}, 32'd3);
        chk("tmo_cycles", sort_cycles, 32'd100);
        chk("tmo_ready", 32'(sort_ready), 32'd0);

        // Reset while a readback is in progress, then a seed-0 run.
        prep(3, 16'h1234, 0);
        length = 6'd3; seed = 16'h1234; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (read_n && c < 500) begin
            @(negedge clk);
            c++;
        end
        chk("mid_reached_check", 32'(read_n), 32'd0);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_rw_sel", {28'd0, read_n, write_n, bus_sel, sort_ready}, 32'd12);
        chk("mid_flags", {29'd0, pass, fail, timeout}, 32'd0);
        chk("mid_cycles", sort_cycles, 32'd0);
        chk("mid_addr", address, 32'd0);
        chk("mid_mem0_old", 32'(mem[0]), 32'h00001234);
        run_test("seed0", 3, 16'h0000, 0, cyc);
        chk("seed0_mem0", 32'(mem[0]), 32'h0000ACE1);
        chk("seed0_pass_fail", {30'd0, pass, fail}, 32'd2);

        chk("bus_ownership", 32'(own_err), 32'd0);
        chk("stall_stable_all", 32'(stable_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sort_test_harness.md
Name: sort_test_harness

Overview:
- Self-test controller that sits directly upstream of the SDRAM insertion sorter, sharing the same 16-bit Avalon-MM SDRAM port through an external 2:1 mux.
- Fills SDRAM words 0..length-1 with LFSR data, then raises the sorter's `ready` and waits for its `done`.
- Reads back the sorted result from words length..2*length-1 and checks that it is non-decreasing and that the checksum is preserved.
- Reports pass/fail and the sort cycle count to HPS/debug LEDs.

Parameters:
- TIMEOUT, 32'd50000000: max cycles in SORT before declaring timeout (1 s at 50 MHz).
- MAX_LEN, 6'd32: largest length the sorter accepts.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- start  in  1  level; rising edge (sampled in IDLE) begins a test
- length  in  6  word count, sampled at start
- seed  in  16  LFSR seed, sampled at start; 0 replaced by 16'hACE1
- waitrequest  in  1  Avalon slave stall
- readdatavalid  in  1  Avalon read data valid
- readdata  in  16  Avalon read data
- read_n  out  1  active-low read
- write_n  out  1  active-low write
- chipselect  out  1  constant 1
- address  out  32  word address
- byteenable  out  2  constant 2'b11
- writedata  out  16  write data
- bus_sel  out  1  mux select; 1 = sorter owns SDRAM port, 0 = this block
- sort_ready  out  1  drives sorter `ready`
- sort_done  in  1  sorter `done`
- busy  out  1  state != IDLE
- pass  out  1  sticky result, cleared on next start
- fail  out  1  sticky result, cleared on next start
- timeout  out  1  sticky; SORT exceeded TIMEOUT
- err_count  out  6  number of order violations found
- sort_cycles  out  32  cycles spent in SORT, saturating

Behaviour:
- Reset: synchronous, active-low; clock clk; reset_n low at any posedge forces IDLE regardless of current state.
- Reset values: read_n=1, write_n=1, address=0, writedata=0, bus_sel=0, sort_ready=0, busy=0, pass=0, fail=0, timeout=0, err_count=0, sort_cycles=0, internal sums=0.
- States: IDLE, FILL, SORT, RELEASE, CHECK, REPORT.
- IDLE:
  - On start rising edge, latch length and seed (seed 0 -> 16'hACE1); clear pass, fail, timeout, err_count, sort_cycles and both sums.
  - length==0: go to REPORT with pass forced; no bus or sorter activity.
  - length>MAX_LEN: go to REPORT with fail forced.
  - Otherwise go to FILL.
- FILL:
  - write_n=0, address=i, writedata=lfsr.
  - A word is accepted in any cycle with write_n==0 and waitrequest==0.
  - On acceptance: i+1, lfsr advances, sum_in += word. The next word is presented the following cycle with write_n kept low (back-to-back allowed).
  - After word length-1 is accepted: write_n=1, go to SORT.
- LFSR: 16-bit Fibonacci; fb = s[0]^s[2]^s[3]^s[5]; next = {fb, s[15:1]}. The written value is the state itself, so it is never 0 (the sorter uses 0 as its empty marker).
- SORT:
  - bus_sel=1, sort_ready=1, read_n=write_n=1; sort_cycles increments each cycle, saturating at 32'hFFFFFFFF.
  - sort_done==1: go to RELEASE.
  - sort_cycles reaching TIMEOUT: set timeout, go to REPORT with fail.
- RELEASE:
  - sort_ready=0, bus_sel stays 1 until sort_done==0 (sorter back in IDLE); then bus_sel=0, go to CHECK.
- CHECK: one read outstanding at a time.
  - read_n=0 with address=length+j until a cycle with waitrequest==0.
  - Then read_n=1; wait for readdatavalid.
  - On data: if j>0 and data<prev, err_count+1 (saturating at 63); sum_out += data; prev=data; j+1.
  - After word length-1 is received, go to REPORT.
  - readdatavalid outside an outstanding read is ignored.
- Sum width: sum_in and sum_out are 22 bits (32*65535 fits).
- REPORT (1 cycle):
  - pass = (err_count==0 && sum_in==sum_out && !timeout).
  - fail = !pass, unless forced by the length rules above.
  - Go to IDLE. pass/fail/err_count/sort_cycles hold until the next start.
- Bus ownership: read_n and write_n are high whenever bus_sel==1, and in IDLE, RELEASE and REPORT.
- start is ignored while busy.

Test Plan:
- seed=16'hACE1, length=3, zero-wait slave, model sorter -> writes 0xACE1,0x5670,0xAB38 to addr 0,1,2; sort_ready rises next cycle; sorted readback 0x5670,0xAB38,0xACE1 -> pass=1, err_count=0.
- Sorter model writes 0x5670,0xACE1,0xAB38 -> err_count=1, fail=1; corrupted word changing the sum with correct order -> fail=1, err_count=0.
- waitrequest held high 3 cycles per access, readdatavalid latency 4 -> writedata/address stable while stalled; exactly length writes and length reads; result identical to the zero-wait case.
- length=0 -> pass=1 within 2 cycles, no read_n/write_n activity; length=40 -> fail=1, no bus activity.
- TIMEOUT=100, sorter never asserts done -> timeout=1, fail=1, sort_cycles=100, sort_ready=0 afterwards.
- reset_n low for 1 cycle mid-CHECK -> all outputs at reset values next cycle; new start with seed=0 uses 0xACE1 and passes.
